// File: rtl/toggle_run_decoder.sv
// Purpose : measures runs of an alternating strobe and reports length, stuck-high error and saturation.
// Latency : report is valid on the edge after the sample that ends the run.
// Backpr. : report holds (valid/data stable) until out_valid & out_ready; strobe/in_en ignored meanwhile.
//
// Ports:
//   iccad_clk, iccad_rst_n   clock, async active-low reset
//   strobe                   toggle stream from upstream generator
//   in_en                    decoder enable; dropping it mid-run discards the run
//   out_ready                consumer accepts report
//   out_valid/out_len/out_err/out_sat  report (data forced to 0 while out_valid=0)
module toggle_run_decoder #(
    parameter int LEN_W = 8
) (
    input  logic             iccad_clk,
    input  logic             iccad_rst_n,
    input  logic             strobe,
    input  logic             in_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_s_q;
    logic               r_seen0;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_err;
    logic               r_sat;
    logic               r_valid;

    state_t             w_state_nxt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic               w_err_nxt;
    logic               w_sat_nxt;
    logic               w_rise;

    // r_s_q resets to 0, which would make a strobe held high through reset look
    // like a rise; r_seen0 demands a genuine 0 sample before any run can start.
    assign w_rise = strobe & ~r_s_q & r_seen0;

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            r_state <= IDLE;
            r_s_q   <= 1'b0;
            r_seen0 <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_s_q   <= strobe;
            r_seen0 <= r_seen0 | ~strobe;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_sat   <= w_sat_nxt;
            r_valid <= (w_state_nxt == REPORT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_sat_nxt   = r_sat;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_err_nxt = 1'b0;
                w_sat_nxt = 1'b0;
                if (in_en && w_rise) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = LEN_W'(1);
                end
            end
            RUN: begin
                if (!in_en) begin
                    // Discard takes priority over any run-ending condition.
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_sat_nxt   = 1'b0;
                end else if (strobe != r_s_q) begin
                    if (r_cnt == {LEN_W{1'b1}}) begin
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                end else begin
                    // Stall: low level is a clean end, high level means stuck.
                    w_state_nxt = REPORT;
                    w_err_nxt   = strobe;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_sat_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_err_nxt   = 1'b0;
                w_sat_nxt   = 1'b0;
            end
        endcase
    end

    assign out_valid = r_valid;
    assign out_len   = r_valid ? r_cnt : '0;
    assign out_err   = r_valid & r_err;
    assign out_sat   = r_valid & r_sat;

endmodule

// File: tb/tb_toggle_run_decoder.sv
// Purpose : directed stimulus for toggle_run_decoder with a queue-based report scoreboard.
// Latency : expected reports carry the cycle on which out_valid must first appear.
// Backpr. : out_ready is driven per scenario, including a held-off consumer.
module tb_toggle_run_decoder;

    logic       clk;
    logic       rst_n;
    logic       strobe;
    logic       in_en;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_len;
    logic       out_err;
    logic       out_sat;

    typedef struct {
        int len;
        int err;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_valid = 1'b0;

    toggle_run_decoder #(.LEN_W(8)) dut (
        .iccad_clk   (clk),
        .iccad_rst_n (rst_n),
        .strobe      (strobe),
        .in_en       (in_en),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_len     (out_len),
        .out_err     (out_err),
        .out_sat     (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present one strobe sample; it is taken at the next rising edge.
    task automatic step(input logic v);
        strobe = v;
        @(posedge clk);
        #1;
    endtask

    // The last step's edge is the run-ending sample, so out_valid must be
    // visible right after it, i.e. in the current cycle number.
    task automatic expect_rpt(input int len, input int err, input int sat);
        exp_t e;
        e.len = len;
        e.err = err;
        e.sat = sat;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: samples on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                if (!prev_valid) chk("valid_cycle", cyc, sb[0].cyc);
                chk("len", int'(out_len), sb[0].len);
                chk("err", int'(out_err), sb[0].err);
                chk("sat", int'(out_sat), sb[0].sat);
                if (out_ready) void'(sb.pop_front());
            end
        end else begin
            chk("idle_data_zero", int'({out_len, out_err, out_sat}), 0);
        end
        prev_valid = out_valid;
    end

    initial begin
        rst_n     = 1'b0;
        strobe    = 1'b0;
        in_en     = 1'b1;
        out_ready = 1'b1;
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data", int'({out_len, out_err, out_sat}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean run of length 4, then back-to-back with minimum gap.
        step(0); step(0); step(1); step(0); step(1); step(0); step(0);
        expect_rpt(4, 0, 0);
        step(0);                                   // handshake cycle
        step(1); step(0); step(1); step(1);        // next rise right after
        expect_rpt(3, 1, 0);
        step(0);

        // Stuck-high end.
        step(0); step(1); step(0); step(1); step(1);
        expect_rpt(3, 1, 0);
        step(0);

        // Saturation with 300 alternating samples.
        step(0);
        for (int i = 0; i < 300; i++) step((i % 2) == 0);
        step(0);
        expect_rpt(255, 0, 1);
        step(0);

        // Held-off consumer with a strobe burst during REPORT.
        out_ready = 1'b0;
        step(0); step(1); step(0); step(0);
        expect_rpt(2, 0, 0);
        step(1); step(0); step(1); step(0); step(1);
        out_ready = 1'b1;
        step(0);
        step(0); step(0);

        // Enable dropped on the third cycle of a run: no report.
        step(0); step(1); step(0);
        in_en = 1'b0;
        step(1); step(0); step(1); step(0);
        in_en = 1'b1;
        step(0); step(0); step(0);

        // Reset during REPORT, then strobe held high must not start a run.
        out_ready = 1'b0;
        step(0); step(1); step(1);
        expect_rpt(1, 1, 0);
        step(0); step(0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_len", int'(out_len), 0);
        chk("async_rst_err", int'(out_err), 0);
        chk("async_rst_sat", int'(out_sat), 0);
        sb.delete();
        strobe = 1'b1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) step(1);

        // A fresh rise after the reset is accepted.
        step(0); step(1); step(0); step(0);
        expect_rpt(2, 0, 0);
        step(0);
        repeat (3) step(0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_run_decoder.md
TOGGLE_RUN_DECODER -- requirements
Module: toggle_run_decoder

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning width of the run-length counter and of out_len.
REQ-002 SHALL have port iccad_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port iccad_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port strobe, input, 1, toggle stream from the upstream toggle generator; when active it alternates every cycle, starting 1 after idling at 0.
REQ-005 SHALL have port in_en, input, 1, decoder enable.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts report.
REQ-007 SHALL have port out_valid, output, 1, report available.
REQ-008 SHALL have port out_len, output, LEN_W, run length in cycles.
REQ-009 SHALL have port out_err, output, 1, run ended stuck-high.
REQ-010 SHALL have port out_sat, output, 1, run length saturated.

Function
REQ-011 SHALL register strobe into s_q every cycle, regardless of state.
REQ-012 SHALL implement FSM states IDLE, RUN and REPORT.
REQ-013 In IDLE, strobe=1 with s_q=0 and in_en=1 SHALL go to RUN with cnt=1; otherwise stay IDLE.
REQ-014 In IDLE, strobe=1 with s_q=1 SHALL NOT start a run (no start mid-level).
REQ-015 In RUN, strobe!=s_q SHALL increment cnt, saturating at 2^LEN_W-1 and setting a sat flag; the FSM stays in RUN.
REQ-016 In RUN, strobe==s_q==0 SHALL end the run cleanly: go to REPORT with err=0.
REQ-017 In RUN, strobe==s_q==1 SHALL end the run with err=1 and go to REPORT.
REQ-018 In RUN, in_en=0 SHALL discard the run, clear cnt and flags, and go to IDLE with no report; this takes priority over REQ-015 to REQ-017.
REQ-019 In REPORT, out_valid SHALL be 1 and out_len, out_err and out_sat SHALL hold constant until a handshake.
REQ-020 A handshake is out_valid=1 and out_ready=1 at a rising edge.
REQ-021 A handshake SHALL go to IDLE and clear cnt, err and sat.
REQ-022 In REPORT, strobe and in_en SHALL be ignored; a strobe rise in the handshake cycle is lost.
REQ-023 out_valid SHALL be registered and SHALL assert on the edge after the run-ending sample (1 cycle after the stall sample).
REQ-024 out_valid SHALL be 0 in IDLE and RUN.
REQ-025 out_len, out_err and out_sat SHALL be 0 whenever out_valid=0.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 Back-to-back runs SHALL be supported; minimum gap from handshake to next accepted rise is 1 cycle (IDLE must sample it).

Reset
REQ-028 iccad_rst_n=0 SHALL asynchronously force IDLE, s_q=0, cnt=0, out_valid=0, out_len=0, out_err=0 and out_sat=0.
REQ-029 Reset asserted mid-RUN or mid-REPORT SHALL drop the run or report with no output.
REQ-030 After reset release, the first run SHALL require a fresh 0->1 strobe transition.

Verification
REQ-031 in_en=1, strobe 0,1,0,1,0,0, out_ready=1 -> one pulse out_valid=1 with out_len=4, out_err=0, out_sat=0, asserted 1 cycle after the second 0 of the 0,0 pair; IDLE next.
REQ-032 strobe 0,1,0,1,1 -> out_len=3, out_err=1.
REQ-033 Alternating strobe for 300 cycles, LEN_W=8 -> out_len=255, out_sat=1.
REQ-034 Run completes with out_ready=0 for 5 cycles -> out_valid and data stable 5 cycles; a strobe burst meanwhile is ignored; handshake on ready=1.
REQ-035 in_en dropped on the 3rd cycle of a run -> no out_valid.
REQ-036 iccad_rst_n pulsed during REPORT -> all outputs 0 immediately (asynchronously); then strobe held 1 -> no run started.
